// File: rtl/ram_copy_engine.sv
// Block copy/fill initiator for a single-port RAM with combinational read.
// Copies use memmove semantics (backward walk when dst > src); fills write a constant.
module ram_copy_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);
    localparam logic [ADDR_W+1:0] DEPTH   = (ADDR_W+2)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] OFF_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] off, off_n;
    logic              mode_r, down_r, err_r;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [ADDR_W:0]   len_r;
    logic [DATA_W-1:0] fill_r;

    logic [ADDR_W+1:0] src_end, dst_end;
    logic              reject, down, last;
    logic              cmd_mode, cmd_err;
    logic [ADDR_W-1:0] cmd_src, cmd_dst;
    logic [DATA_W-1:0] cmd_fill;
    logic              busy_d, done_d, error_d, load_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] in_d;

    // Range sums carry two extra bits so nothing wraps before the compare.
    assign src_end = {2'b00, src_addr} + {1'b0, len};
    assign dst_end = {2'b00, dst_addr} + {1'b0, len};
    assign reject  = (!mode && (src_end > DEPTH)) || (dst_end > DEPTH);
    assign down    = !mode && (dst_addr > src_addr);
    assign last    = down_r ? (off == '0) : ({1'b0, off} == (len_r - LEN_ONE));

    always_comb begin
        state_n = state;
        off_n   = off;
        case (state)
            IDLE: begin
                if (start) begin
                    if (reject || (len == '0)) state_n = FIN;
                    else if (mode)             state_n = WRITE;
                    else                       state_n = READ;
                    off_n = down ? ADDR_W'(len - LEN_ONE) : '0;
                end
            end
            READ:  state_n = WRITE;
            WRITE: begin
                if (last) begin
                    state_n = FIN;
                end else begin
                    state_n = mode_r ? WRITE : READ;
                    off_n   = down_r ? (off - OFF_ONE) : (off + OFF_ONE);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    // In IDLE the command is taken straight from the inputs being latched this edge.
    always_comb begin
        cmd_mode = (state == IDLE) ? mode       : mode_r;
        cmd_err  = (state == IDLE) ? reject     : err_r;
        cmd_src  = (state == IDLE) ? src_addr   : src_r;
        cmd_dst  = (state == IDLE) ? dst_addr   : dst_r;
        cmd_fill = (state == IDLE) ? fill_value : fill_r;
        busy_d   = (state_n == READ) || (state_n == WRITE);
        done_d   = (state_n == FIN);
        error_d  = done_d && cmd_err;
        load_d   = (state_n == WRITE);
        addr_d   = mem_address;
        in_d     = mem_in;
        if (state_n == READ) addr_d = cmd_src + off_n;
        if (state_n == WRITE) begin
            addr_d = cmd_dst + off_n;
            in_d   = cmd_mode ? cmd_fill : mem_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            off         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_load    <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
        end else begin
            state       <= state_n;
            off         <= off_n;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            mem_load    <= load_d;
            mem_address <= addr_d;
            mem_in      <= in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mode_r <= mode;
            down_r <= down;
            err_r  <= reject;
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            len_r  <= len;
            fill_r <= fill_value;
        end
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: RAM model, memmove-level reference and per-cycle compare.
module tb_ram_copy_engine;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef struct packed {
        bit          busy;
        bit          done;
        bit          err;
        bit          load;
        bit          chk_addr;
        logic [2:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic [DATA_W-1:0] fill_value = '0;
    logic              busy, done, error, mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in, mem_out;

    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] mref    [DEPTH];
    logic [DATA_W-1:0] pre_val [DEPTH];
    bit                pre_en = 1'b0;

    exp_t       expq[$];
    logic [2:0] wr_addrs[$];
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, load_cnt = 0;

    ram_copy_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pre_val[i];
        end else if (mem_load) begin
            ram[mem_address] <= mem_in;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Per-cycle compare against the expectation queue; an empty queue means idle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        e = '{default: 0};
        if (expq.size() > 0) e = expq.pop_front();
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("error", error, e.err);
        chk("mem_load", mem_load, e.load);
        if (e.chk_addr) chk("mem_address", mem_address, e.addr);
        if (e.load)     chk("mem_in", mem_in, e.data);
        if (mem_load) begin
            load_cnt++;
            wr_addrs.push_back(mem_address);
        end
        if (done) done_cyc = cyc;
    end

    // Reference: memmove semantics from a snapshot, plus the cycle schedule of each command.
    task automatic model_cmd(input bit m, input int s, input int d, input int l,
                             input int f, input int limit);
        exp_t        e;
        logic [15:0] orig [DEPTH];
        logic [15:0] w;
        bit          rej, bwd;
        int          off;
        rej  = (!m && (s + l > DEPTH)) || (d + l > DEPTH);
        orig = mref;
        if (rej || l == 0) begin
            e = '{default: 0};
            e.done = 1'b1;
            e.err  = rej;
            expq.push_back(e);
            return;
        end
        bwd = !m && (d > s);
        for (int k = 0; k < l; k++) begin
            off = bwd ? (l - 1 - k) : k;
            w   = m ? f[15:0] : orig[s + off];
            if (!m) begin
                e = '{default: 0};
                e.busy = 1'b1; e.chk_addr = 1'b1; e.addr = 3'(s + off);
                expq.push_back(e);
            end
            e = '{default: 0};
            e.busy = 1'b1; e.load = 1'b1; e.chk_addr = 1'b1;
            e.addr = 3'(d + off); e.data = w;
            expq.push_back(e);
            if (k < limit) mref[d + off] = w;
        end
        e = '{default: 0};
        e.done = 1'b1;
        expq.push_back(e);
    endtask

    task automatic preload(input int base, input int step);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            pre_val[i] = 16'(base + i * step);
            mref[i]    = 16'(base + i * step);
        end
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input bit m, input int s, input int d, input int l,
                         input int f, input int limit);
        @(negedge clk);
        mode = m; src_addr = ADDR_W'(s); dst_addr = ADDR_W'(d);
        len = (ADDR_W+1)'(l); fill_value = 16'(f);
        start = 1'b1;
        start_cyc = cyc;
        load_cnt = 0;
        done_cyc = -1;
        wr_addrs.delete();
        model_cmd(m, s, d, l, f, limit);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (expq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() > 0) begin
            checks++; errors++;
            $display("FAIL wait_idle: %0d entries left after %0d cycles", expq.size(), n);
            expq.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_ram();
        for (int i = 0; i < DEPTH; i++) chk($sformatf("ram[%0d]", i), ram[i], mref[i]);
    endtask

    task automatic chk_lit(input string nm, input int v[8]);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("%s[%0d]", nm, i), ram[i], 32'(v[i]));
    endtask

    task automatic chk_order(input string nm, input int v[5]);
        chk({nm, "_count"}, wr_addrs.size(), 5);
        for (int i = 0; i < 5 && i < wr_addrs.size(); i++) chk(nm, wr_addrs[i], 32'(v[i]));
    endtask

    initial begin
        int lit[8];
        int ord[5];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_load", mem_load, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_in", mem_in, 0);

        // Plain non-overlapping copy
        preload(32'h1000, 1);
        issue(1'b0, 0, 4, 4, 0, 99);
        chk("model_len_copy4", expq.size(), 8);
        wait_idle();
        chk("lat_copy4", done_cyc - start_cyc, 9);
        chk("loads_copy4", load_cnt, 4);
        lit = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1000, 32'h1001, 32'h1002, 32'h1003};
        chk_lit("copy4", lit);

        // Overlap, dst above src: backward walk
        preload(0, 1);
        issue(1'b0, 0, 2, 5, 0, 99);
        wait_idle();
        lit = '{0, 1, 0, 1, 2, 3, 4, 7};
        chk_lit("ovl_fwd", lit);
        ord = '{6, 5, 4, 3, 2};
        chk_order("ovl_fwd_order", ord);

        // Overlap, dst below src: forward walk
        preload(0, 1);
        issue(1'b0, 3, 1, 5, 0, 99);
        wait_idle();
        lit = '{0, 3, 4, 5, 6, 7, 6, 7};
        chk_lit("ovl_bwd", lit);
        ord = '{1, 2, 3, 4, 5};
        chk_order("ovl_bwd_order", ord);

        // Fill
        issue(1'b1, 0, 2, 3, 32'hBEEF, 99);
        wait_idle();
        chk("lat_fill3", done_cyc - start_cyc, 4);
        chk("loads_fill3", load_cnt, 3);
        chk("fill_ram2", ram[2], 32'hBEEF);
        chk("fill_ram4", ram[4], 32'hBEEF);
        chk_ram();

        // Reject, empty and full-depth boundary
        issue(1'b0, 6, 0, 3, 0, 99);
        wait_idle();
        chk("lat_reject", done_cyc - start_cyc, 1);
        chk("loads_reject", load_cnt, 0);
        issue(1'b0, 1, 2, 0, 0, 99);
        wait_idle();
        chk("lat_len0", done_cyc - start_cyc, 1);
        chk("loads_len0", load_cnt, 0);
        issue(1'b0, 0, 0, 8, 0, 99);
        wait_idle();
        chk("lat_len8", done_cyc - start_cyc, 17);
        chk("loads_len8", load_cnt, 8);
        chk_ram();

        // start pulsed while busy must not disturb the running copy
        preload(32'h2000, 3);
        issue(1'b0, 0, 4, 3, 0, 99);
        @(negedge clk);
        mode = 1'b1; dst_addr = '0; len = 4'd8; fill_value = 16'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("loads_busy_start", load_cnt, 3);
        chk_ram();

        // Asynchronous reset during a WRITE cycle of a copy
        preload(32'h3000, 1);
        issue(1'b0, 0, 4, 4, 0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        chk("load_before_rst", mem_load, 1);
        #1;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("rst_mid_load", mem_load, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_address, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ram();
        issue(1'b1, 1, 0, 5, 32'h5A5A, 99);
        wait_idle();
        chk("lat_fill_after_rst", done_cyc - start_cyc, 6);
        chk_ram();

        // Randomized commands
        preload(32'h4000, 7);
        for (int t = 0; t < 30; t++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 16'hFFFF)), 99);
            wait_idle();
            chk_ram();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
